// File: rtl/ama_riscv_mem_arbiter.sv
// Arbitrates instruction fetch and data access onto one single-port synchronous RAM.
// Data wins conflicts until fetch has lost STARVE_MAX times in a row, then fetch wins once.
module ama_riscv_mem_arbiter #(
  parameter int AW         = 14,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  // fetch channel
  input  logic          imem_req_valid,
  output logic          imem_req_ready,
  input  logic [AW-1:0] imem_req_addr,
  output logic          imem_rsp_valid,
  output logic [31:0]   imem_rsp_data,
  // data channel
  input  logic          dmem_req_valid,
  output logic          dmem_req_ready,
  input  logic [AW-1:0] dmem_req_addr,
  input  logic [3:0]    dmem_req_we,
  input  logic [31:0]   dmem_req_wdata,
  output logic          dmem_rsp_valid,
  output logic [31:0]   dmem_rsp_data,
  // RAM
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [0:0] PRIO_D = 1'b0;
  localparam logic [0:0] PRIO_I = 1'b1;

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_IMEM  = 2'd1;
  localparam logic [1:0] OWN_DLOAD = 2'd2;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [0:0] state;
  logic [3:0] starve_cnt;
  logic [1:0] owner;
  logic       conflict;
  logic       i_acc;
  logic       d_acc;

  // A lone requester always sees ready; priority only matters on conflict.
  assign imem_req_ready = !dmem_req_valid || (state == PRIO_I);
  assign dmem_req_ready = !imem_req_valid || (state == PRIO_D);

  assign conflict = imem_req_valid && dmem_req_valid;
  assign i_acc    = imem_req_valid && imem_req_ready;
  assign d_acc    = dmem_req_valid && dmem_req_ready;

  assign mem_en    = (i_acc || d_acc) && !rst;
  assign mem_we    = (d_acc && !rst) ? dmem_req_we : 4'b0;
  assign mem_addr  = d_acc ? dmem_req_addr : imem_req_addr;
  assign mem_wdata = d_acc ? dmem_req_wdata : 32'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PRIO_D;
      starve_cnt <= 4'd0;
      owner      <= OWN_NONE;
    end else begin
      if (i_acc) begin
        state      <= PRIO_D;
        starve_cnt <= 4'd0;
      end else if (conflict && d_acc) begin
        starve_cnt <= starve_cnt + 4'd1;
        if (starve_cnt + 4'd1 == SMAX) state <= PRIO_I;
      end
      // Stores leave no owner, so they never produce a response.
      if (i_acc)                          owner <= OWN_IMEM;
      else if (d_acc && dmem_req_we == 4'b0) owner <= OWN_DLOAD;
      else                                owner <= OWN_NONE;
    end
  end

  // Gate with rst so a read in flight when reset hits is silently dropped.
  assign imem_rsp_valid = (owner == OWN_IMEM)  && !rst;
  assign dmem_rsp_valid = (owner == OWN_DLOAD) && !rst;
  assign imem_rsp_data  = imem_rsp_valid ? mem_rdata : 32'b0;
  assign dmem_rsp_data  = dmem_rsp_valid ? mem_rdata : 32'b0;

endmodule
